// File: rtl/i_serdes_deser.sv
// Serial-to-parallel receiver: MSB-first WIDTH-bit word assembly with channel-bond sync and bitslip.
// Optional macro I_SERDES_SLIP_COUNT_EN adds the SLIP_CNT output counting applied slips.
module i_serdes_deser #(
    parameter int WIDTH = 4
) (
    input  logic             PLL_CLK,
    input  logic             RST,
    input  logic             PLL_LOCK,
    input  logic             D,
    input  logic             EN,
    input  logic             BITSLIP_ADJ,
    input  logic             CHANNEL_BOND_SYNC_IN,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID,
    output logic             CHANNEL_BOND_SYNC_OUT
`ifdef I_SERDES_SLIP_COUNT_EN
    ,
    output logic [3:0]       SLIP_CNT
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shift;
    logic               slip_pending;
    logic               bitslip_q;

    logic               take_first;
    logic               shift_en;
    logic               slip_apply;
    logic               slip_req;
    logic               word_done;

    always_ff @(posedge PLL_CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        take_first = 1'b0;
        shift_en   = 1'b0;
        slip_apply = 1'b0;
        if (!PLL_LOCK) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  state_next = ALIGN;
                ALIGN: if (EN && CHANNEL_BOND_SYNC_IN) begin
                    state_next = RUN;
                    take_first = 1'b1;
                end
                RUN:   if (EN) begin
                    if (slip_pending) slip_apply = 1'b1;
                    else              shift_en   = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign word_done             = shift_en && (bit_cnt == CNT_W'(WIDTH - 1));
    // A request landing while one is still pending is dropped, not queued.
    assign slip_req              = PLL_LOCK && (state == RUN) && BITSLIP_ADJ && !bitslip_q && !slip_pending;
    assign CHANNEL_BOND_SYNC_OUT = (state == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PLL_CLK or posedge RST) begin
        if (RST) begin
            Q            <= '0;
            DATA_VALID   <= 1'b0;
            bit_cnt      <= '0;
            shift        <= '0;
            slip_pending <= 1'b0;
            bitslip_q    <= 1'b0;
        end else begin
            bitslip_q  <= BITSLIP_ADJ;
            DATA_VALID <= 1'b0;
            if (!PLL_LOCK) begin
                bit_cnt      <= '0;
                shift        <= '0;
                slip_pending <= 1'b0;
            end else begin
                if (take_first) begin
                    shift   <= {{(WIDTH-1){1'b0}}, D};
                    bit_cnt <= CNT_W'(1);
                end
                if (shift_en) begin
                    shift <= {shift[WIDTH-2:0], D};
                    if (word_done) begin
                        Q          <= {shift[WIDTH-2:0], D};
                        DATA_VALID <= 1'b1;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (slip_apply)    slip_pending <= 1'b0;
                else if (slip_req) slip_pending <= 1'b1;
            end
        end
    end

`ifdef I_SERDES_SLIP_COUNT_EN
    always_ff @(posedge PLL_CLK or posedge RST) begin
        if (RST) begin
            SLIP_CNT <= 4'd0;
        end else if (!PLL_LOCK) begin
            SLIP_CNT <= 4'd0;
        end else if (slip_apply) begin
            SLIP_CNT <= (SLIP_CNT == 4'(WIDTH - 1)) ? 4'd0 : SLIP_CNT + 4'd1;
        end
    end
`else
    // Slip counter not built in this configuration.
`endif

endmodule
